// File: rtl/key_debounce.sv
// Push-button front end: synchronises raw active-low keys, filters bounce and
// produces debounced levels plus press/release/auto-repeat pulses per key.
module key_debounce #(
  parameter int KEYS            = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic            clk100_i,
  input  logic            rst_i,
  input  logic [KEYS-1:0] key_i,
  input  logic [KEYS-1:0] repeat_en_i,
  output logic [KEYS-1:0] key_state_o,
  output logic [KEYS-1:0] key_press_o,
  output logic [KEYS-1:0] key_release_o,
  output logic [KEYS-1:0] key_repeat_o
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  // Bit 1 of the state encoding is the debounced level, so it doubles as the output flop.
  localparam logic [1:0] RELEASED    = 2'd0;
  localparam logic [1:0] PRESS_CHK   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] RELEASE_CHK = 2'd3;

  for (genvar g = 0; g < KEYS; g++) begin : g_key
    logic          sync_a;
    logic          sync_b;
    logic [1:0]    state;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] rpt_cnt;
    logic          rpt_phase;
    logic          press;
    logic          release_p;
    logic          rpt;
    logic          rpt_due;

    // rpt_phase=0 while waiting for the initial delay, 1 once periodic repeats have begun.
    assign rpt_due = rpt_phase ? (rpt_cnt == PERIOD_LAST) : (rpt_cnt == DELAY_LAST);

    always_ff @(posedge clk100_i) begin
      if (rst_i) begin
        sync_a    <= 1'b1;
        sync_b    <= 1'b1;
        state     <= RELEASED;
        deb_cnt   <= '0;
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
        press     <= 1'b0;
        release_p <= 1'b0;
        rpt       <= 1'b0;
      end else begin
        sync_a    <= key_i[g];
        sync_b    <= sync_a;
        press     <= 1'b0;
        release_p <= 1'b0;
        rpt       <= 1'b0;

        case (state)
          RELEASED: begin
            deb_cnt <= '0;
            if (!sync_b) state <= PRESS_CHK;
          end

          PRESS_CHK: begin
            if (sync_b) begin
              state   <= RELEASED;
              deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
              state     <= HELD;
              deb_cnt   <= '0;
              press     <= 1'b1;
              rpt_cnt   <= '0;
              rpt_phase <= 1'b0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end

          HELD: begin
            deb_cnt <= '0;
            if (sync_b) state <= RELEASE_CHK;
            if (!repeat_en_i[g]) begin
              rpt_cnt   <= '0;
              rpt_phase <= 1'b0;
            end else if (rpt_due) begin
              press     <= 1'b1;
              rpt       <= 1'b1;
              rpt_cnt   <= '0;
              rpt_phase <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end

          RELEASE_CHK: begin
            // Repeat timing is frozen here so a release glitch only delays the next repeat.
            if (!repeat_en_i[g]) begin
              rpt_cnt   <= '0;
              rpt_phase <= 1'b0;
            end
            if (!sync_b) begin
              state   <= HELD;
              deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
              state     <= RELEASED;
              deb_cnt   <= '0;
              release_p <= 1'b1;
              rpt_cnt   <= '0;
              rpt_phase <= 1'b0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end

          default: begin
            state   <= RELEASED;
            deb_cnt <= '0;
          end
        endcase
      end
    end

    assign key_state_o[g]   = state[1];
    assign key_press_o[g]   = press;
    assign key_release_o[g] = release_p;
    assign key_repeat_o[g]  = rpt;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: each stimulus pushes the pulses it must cause,
// and a per-cycle monitor compares every output against the pending expectations.
module tb_key_debounce;
  localparam int D   = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = 2 + D;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_REPEAT  = 2;
  localparam int K_RESET   = 3;

  typedef struct {
    int at;
    int key;
    int kind;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [1:0] repeat_en;
  logic [1:0] key_state;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [1:0] key_repeat;

  ev_t        sb[$];
  int         edge_n = 0;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_state = 2'b00;
  int         p;

  always #5 clk = ~clk;

  key_debounce #(
    .KEYS(2),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk100_i(clk),
    .rst_i(rst),
    .key_i(key),
    .repeat_en_i(repeat_en),
    .key_state_o(key_state),
    .key_press_o(key_press),
    .key_release_o(key_release),
    .key_repeat_o(key_repeat)
  );

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expectEvent(input int at, input int k, input int kind);
    ev_t e;
    e.at = at;
    e.key = k;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [1:0] keys, input logic [1:0] en);
    key = keys;
    repeat_en = en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int e);
    while (edge_n < e) step();
  endtask

  // Expected pulses for the edge just taken are pulled out of the scoreboard.
  always @(negedge clk) begin : monitor
    logic [1:0] ep;
    logic [1:0] er;
    logic [1:0] erp;
    ep = 2'b00;
    er = 2'b00;
    erp = 2'b00;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == edge_n) begin
        case (sb[i].kind)
          K_PRESS:   begin ep[sb[i].key] = 1'b1; exp_state[sb[i].key] = 1'b1; end
          K_RELEASE: begin er[sb[i].key] = 1'b1; exp_state[sb[i].key] = 1'b0; end
          K_REPEAT:  begin ep[sb[i].key] = 1'b1; erp[sb[i].key] = 1'b1; end
          default:   exp_state[sb[i].key] = 1'b0;
        endcase
        sb.delete(i);
      end
    end
    if (edge_n >= 1) begin
      checkOutput($sformatf("press@%0d", edge_n), 32'(key_press), 32'(ep));
      checkOutput($sformatf("release@%0d", edge_n), 32'(key_release), 32'(er));
      checkOutput($sformatf("repeat@%0d", edge_n), 32'(key_repeat), 32'(erp));
      checkOutput($sformatf("state@%0d", edge_n), 32'(key_state), 32'(exp_state));
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(2'b11, 2'b00);
    step();
    step();
    step();
    rst = 1'b0;

    // Clean press on key 0: low sampled from edge 10, press at 16
    waitUntil(9);
    applyStimulus(2'b10, 2'b00);
    expectEvent(edge_n + 1 + LAT, 0, K_PRESS);
    repeat (30) step();
    applyStimulus(2'b11, 2'b00);
    expectEvent(edge_n + 1 + LAT, 0, K_RELEASE);
    repeat (12) step();

    // Bounce on key 1 every 2 cycles, then a long hold with repeat disabled
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 2'b01 : 2'b11, 2'b00);
      step();
      step();
    end
    applyStimulus(2'b01, 2'b00);
    expectEvent(edge_n + 1 + LAT, 1, K_PRESS);
    repeat (60) step();
    applyStimulus(2'b11, 2'b00);
    expectEvent(edge_n + 1 + LAT, 1, K_RELEASE);
    repeat (12) step();

    // Auto-repeat on key 0
    applyStimulus(2'b11, 2'b01);
    step();
    applyStimulus(2'b10, 2'b01);
    p = edge_n + 1 + LAT;
    expectEvent(p, 0, K_PRESS);
    for (int n = 0; n < 5; n++) expectEvent(p + RD + n * RP, 0, K_REPEAT);
    waitUntil(p + 53);
    applyStimulus(2'b11, 2'b01);
    expectEvent(edge_n + 1 + LAT, 0, K_RELEASE);
    repeat (12) step();

    // Simultaneous press and release on both keys
    applyStimulus(2'b00, 2'b00);
    expectEvent(edge_n + 1 + LAT, 0, K_PRESS);
    expectEvent(edge_n + 1 + LAT, 1, K_PRESS);
    repeat (15) step();
    applyStimulus(2'b11, 2'b00);
    expectEvent(edge_n + 1 + LAT, 0, K_RELEASE);
    expectEvent(edge_n + 1 + LAT, 1, K_RELEASE);
    repeat (12) step();

    // Release glitch of 3 cycles while held: repeats slip by 3 edges
    applyStimulus(2'b11, 2'b01);
    step();
    applyStimulus(2'b10, 2'b01);
    p = edge_n + 1 + LAT;
    expectEvent(p, 0, K_PRESS);
    waitUntil(p + 9);
    applyStimulus(2'b11, 2'b01);
    step();
    step();
    step();
    applyStimulus(2'b10, 2'b01);
    expectEvent(p + RD + 3, 0, K_REPEAT);
    expectEvent(p + RD + 3 + RP, 0, K_REPEAT);
    waitUntil(p + 33);
    applyStimulus(2'b11, 2'b01);
    expectEvent(edge_n + 1 + LAT, 0, K_RELEASE);
    repeat (12) step();

    // Reset pulse while key 0 is held; key still low afterwards is a new press
    applyStimulus(2'b11, 2'b00);
    step();
    applyStimulus(2'b10, 2'b00);
    p = edge_n + 1 + LAT;
    expectEvent(p, 0, K_PRESS);
    waitUntil(p + 5);
    rst = 1'b1;
    expectEvent(p + 6, 0, K_RESET);
    step();
    rst = 1'b0;
    expectEvent(edge_n + 1 + LAT, 0, K_PRESS);
    repeat (10) step();
    applyStimulus(2'b11, 2'b00);
    expectEvent(edge_n + 1 + LAT, 0, K_RELEASE);
    repeat (12) step();

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounce and event generator for the board push-buttons. Takes the raw, active-low `key_i` lines, synchronises them to `clk100_i`, filters contact bounce, and drives clean debounced levels plus one-cycle press/release pulses with optional auto-repeat. It is the producer end of the key interface: the counter and other lab blocks consume its pulses instead of raw buttons.

## Interface
- `KEYS`, 2: number of independent key channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronised samples required to accept a level change (10 ms at 50 MHz). Must be ≥1.
- `REPEAT_DELAY`, 25000000: cycles from the press pulse to the first repeat pulse. Must be ≥1.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat pulses. Must be ≥1.

- `clk100_i`  in  1  system clock, all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `key_i`  in  KEYS  raw buttons, asynchronous, active-low (0 = pressed).
- `repeat_en_i`  in  KEYS  per-key auto-repeat enable, synchronous.
- `key_state_o`  out  KEYS  debounced level, 1 = pressed.
- `key_press_o`  out  KEYS  one-cycle pulse on accepted press and on every repeat.
- `key_release_o`  out  KEYS  one-cycle pulse on accepted release.
- `key_repeat_o`  out  KEYS  high only in cycles where `key_press_o` is a repeat pulse.

## Operation
- Per key: 2-flop synchroniser, reset value 1 (released). The synchronised sample `s` drives a 4-state FSM with a debounce counter and a repeat counter. All keys are fully independent.
- RELEASED: `key_state_o`=0. If `s`=0, go to PRESS_CHK with the debounce count started.
- PRESS_CHK: `key_state_o`=0. Count consecutive cycles with `s`=0. Any `s`=1 returns to RELEASED and clears the count. After `DEBOUNCE_CYCLES` stable samples, go to HELD, set `key_state_o`=1, pulse `key_press_o`, and clear the repeat counter.
- HELD: `key_state_o`=1. If `s`=1, go to RELEASE_CHK. If `repeat_en_i`=1, the repeat counter runs:
  - at `REPEAT_DELAY` after the press pulse, pulse `key_press_o` and `key_repeat_o`;
  - thereafter, pulse both every `REPEAT_PERIOD` cycles.
- RELEASE_CHK: `key_state_o`=1. Any `s`=0 returns to HELD. After `DEBOUNCE_CYCLES` consecutive `s`=1 samples, go to RELEASED, set `key_state_o`=0, and pulse `key_release_o`.
- Repeat counter behaviour:
  - Paused (held, not cleared) in RELEASE_CHK.
  - Cleared while `repeat_en_i`=0. Re-asserting `repeat_en_i` restarts the `REPEAT_DELAY` phase from 0.
- Counter widths: `$clog2` of the largest parameter + 1. No wrap is possible because counters clear on every state exit.
- `key_press_o` and `key_release_o` of one key are never high in the same cycle.
- Simultaneous events on different keys produce pulses in the same cycle.

## Timing
- Reset values:
  - all `*_o` = 0;
  - FSMs in RELEASED;
  - synchronisers = 1;
  - counters = 0.
- `rst_i` asserted mid-operation wins in the same edge: outputs are 0 after that edge.
- A key still held low when `rst_i` deasserts is treated as a new press.
- Press latency: `key_i` low and stable from edge k → `key_state_o`=1 and `key_press_o`=1 after edge k+2+`DEBOUNCE_CYCLES`, for exactly one cycle.
- Release latency: identical, 2+`DEBOUNCE_CYCLES` edges after `key_i` returns high.
- Repeat pulses: at press-pulse edge + `REPEAT_DELAY`, then + `REPEAT_PERIOD` × n. Each repeat pulse is offset by the number of cycles spent in RELEASE_CHK.
- A bounce shorter than `DEBOUNCE_CYCLES` samples produces no output change.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8, `KEYS`=2.
- Clean press: `key_i[0]` low from edge 10 for 30 cycles, then high → `key_press_o[0]` high only after edge 16 and `key_state_o[0]` rises there; `key_release_o[0]` is a single pulse 6 edges after the release edge; no other pulses.
- Bounce: `key_i[1]` toggled every 2 cycles for 20 cycles, then held low → no outputs during toggling; exactly one press pulse 6 edges after the final fall.
- Auto-repeat: `repeat_en_i[0]`=1, hold for 60 cycles after the press pulse at edge P → repeat pulses at P+20, P+28, P+36, P+44, P+52 with `key_repeat_o[0]` coincident; with `repeat_en_i`=0 only the pulse at P.
- Simultaneous: both keys low at the same edge → both `key_press_o` bits pulse in the same cycle; a later simultaneous release gives both `key_release_o` bits in the same cycle.
- Release glitch: in HELD, `key_i[0]` high for 3 cycles → no release pulse, `key_state_o[0]` stays 1, and the next repeat is delayed by the time spent in RELEASE_CHK.
- Reset mid-hold: `rst_i` pulsed for 1 cycle while in HELD with the key still low → all outputs 0 after the reset edge; new press pulse 6 edges after `rst_i` deasserts.
